vliw_issue_scoreboard: RTL

//  Issue-stage hazard controller for the NFU-port register file. Tracks in-flight writes per register,

---
 rtl/vliw_issue_scoreboard_pkg.sv | 28 ++
 rtl/vliw_issue_scoreboard_entry.sv | 44 ++++
 rtl/vliw_issue_scoreboard.sv | 125 ++++++++++++
 3 files changed

// File: rtl/vliw_issue_scoreboard_pkg.sv
// Shared types for the VLIW issue scoreboard: register address and latency
// widths, the per-slot issue record, and the effective-latency helper.
package vliw_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 64;
    localparam int NREG       = 32;
    localparam int NFU        = 2;
    localparam int LATW       = 3;

    typedef logic [REG_ADDR_W-1:0] regAddr_t;
    typedef logic [LATW-1:0]       latency_t;

    typedef struct packed {
        logic           valid;
        regAddr_t [2:0] src;
        logic [2:0]     srcUse;
        regAddr_t       dst;
        logic           dstWrite;
        latency_t       latency;
    } issueSlot_t;

    // A zero latency still occupies the register for one cycle.
    function automatic latency_t eff_latency(input latency_t lat);
        return (lat == {LATW{1'b0}}) ? {{(LATW-1){1'b0}}, 1'b1} : lat;
    endfunction

endpackage

// File: rtl/vliw_issue_scoreboard_entry.sv
// One scoreboard entry: a down-counter of cycles until the in-flight write
// to this register lands, plus a registered pending flag kept in step with it.
module scoreboard_entry #(
    parameter int LATW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [LATW-1:0] loadValue,
    input  logic            flush,
    output logic [LATW-1:0] count,
    output logic            pending
);

    localparam logic [LATW-1:0] ZERO = {LATW{1'b0}};
    localparam logic [LATW-1:0] ONE  = {{(LATW-1){1'b0}}, 1'b1};

    logic [LATW-1:0] count_r;
    logic            pending_r;

    // Counter update: reset/flush clear, load wins over decrement
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r   <= ZERO;
            pending_r <= 1'b0;
        end else if (flush) begin
            count_r   <= ZERO;
            pending_r <= 1'b0;
        end else if (load) begin
            count_r   <= loadValue;
            pending_r <= (loadValue != ZERO);
        end else if (count_r != ZERO) begin
            count_r   <= count_r - ONE;
            pending_r <= (count_r != ONE);
        end else begin
            count_r   <= count_r;
            pending_r <= pending_r;
        end
    end

    assign count   = count_r;
    assign pending = pending_r;

endmodule

// File: rtl/vliw_issue_scoreboard.sv
// Issue-stage hazard controller: tracks pending register writes, accepts or
// stalls each VLIW bundle and drives the per-slot register-file enables.
module vliw_issue_scoreboard
    import vliw_pkg::*;
#(
    parameter int NFU  = 2,
    parameter int NREG = 32,
    parameter int LATW = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             issueValid,
    output logic                             issueReady,
    input  logic [NFU-1:0]                   slotValid,
    input  logic [NFU-1:0][REG_ADDR_W-1:0]   srcAddr1,
    input  logic [NFU-1:0][REG_ADDR_W-1:0]   srcAddr2,
    input  logic [NFU-1:0][REG_ADDR_W-1:0]   srcAddr3,
    input  logic [NFU-1:0][2:0]              srcUse,
    input  logic [NFU-1:0][REG_ADDR_W-1:0]   dstAddr,
    input  logic [NFU-1:0]                   dstWrite,
    input  logic [NFU-1:0][LATW-1:0]         dstLatency,
    input  logic                             flush,
    output logic [NFU-1:0]                   rfEnable,
    output logic                             bundleError,
    output logic [NREG-1:0]                  busyMask,
    output logic [31:0]                      stallCount
);

    issueSlot_t [NFU-1:0]            slot_s;
    logic [NFU-1:0]                  hazard_s;
    logic                            dup_s;
    logic                            ready_s;
    logic [NREG-1:0]                 pending_s;
    logic [NREG-1:0]                 load_s;
    logic [NREG-1:0][LATW-1:0]       load_val_s;
    logic [NREG-1:0][LATW-1:0]       count_s;
    logic [31:0]                     stall_r;

    // Gather the per-slot decode fields into slot records
    always_comb begin
        slot_s = '0;
        for (int i = 0; i < NFU; i++) begin
            slot_s[i].valid    = slotValid[i];
            slot_s[i].src[0]   = srcAddr1[i];
            slot_s[i].src[1]   = srcAddr2[i];
            slot_s[i].src[2]   = srcAddr3[i];
            slot_s[i].srcUse   = srcUse[i];
            slot_s[i].dst      = dstAddr[i];
            slot_s[i].dstWrite = dstWrite[i];
            slot_s[i].latency  = dstLatency[i];
        end
    end

    // RAW/WAW against the pre-bundle pending state; slots never see each other
    always_comb begin
        hazard_s = '0;
        for (int i = 0; i < NFU; i++) begin
            for (int k = 0; k < 3; k++) begin
                hazard_s[i] = hazard_s[i] |
                    (slot_s[i].valid & slot_s[i].srcUse[k] & pending_s[slot_s[i].src[k]]);
            end
            hazard_s[i] = hazard_s[i] |
                (slot_s[i].valid & slot_s[i].dstWrite & pending_s[slot_s[i].dst]);
        end
    end

    // Two live writers of the same register in one bundle
    always_comb begin
        dup_s = 1'b0;
        for (int i = 0; i < NFU; i++) begin
            for (int j = i + 1; j < NFU; j++) begin
                dup_s = dup_s | (slot_s[i].valid & slot_s[i].dstWrite &
                                 slot_s[j].valid & slot_s[j].dstWrite &
                                 (slot_s[i].dst == slot_s[j].dst));
            end
        end
    end

    assign ready_s     = issueValid & ~rst & ~flush & ~dup_s & ~(|hazard_s);
    assign issueReady  = ready_s;
    assign bundleError = dup_s;
    assign rfEnable    = slotValid & {NFU{ready_s}};

    // Route accepted writes to their register entries; at most one hit per register
    always_comb begin
        load_s     = '0;
        load_val_s = '0;
        for (int r = 0; r < NREG; r++) begin
            for (int i = 0; i < NFU; i++) begin
                logic hit;
                hit = ready_s & slot_s[i].valid & slot_s[i].dstWrite &
                      (slot_s[i].dst == REG_ADDR_W'(r));
                load_s[r]     = load_s[r] | hit;
                load_val_s[r] = load_val_s[r] | ({LATW{hit}} & eff_latency(slot_s[i].latency));
            end
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_entry
        scoreboard_entry #(.LATW(LATW)) u_entry (
            .clk       (clk),
            .rst       (rst),
            .load      (load_s[g]),
            .loadValue (load_val_s[g]),
            .flush     (flush),
            .count     (count_s[g]),
            .pending   (pending_s[g])
        );
    end

    // Saturating count of cycles a presented bundle is held back
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_r <= 32'd0;
        end else if (issueValid && !ready_s && !flush && (stall_r != 32'hFFFF_FFFF)) begin
            stall_r <= stall_r + 32'd1;
        end else begin
            stall_r <= stall_r;
        end
    end

    assign busyMask   = pending_s;
    assign stallCount = stall_r;

endmodule
